lane_dly_move_ctrl: RTL and testbench

//  Fabric-side sequencer directly upstream of the LPDDR3 lane controller.

---
 rtl/lane_dly_move_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lane_dly_move_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_dly_move_ctrl.sv
// lane_dly_move_ctrl: turns one "move RX/TX DQS delay line by N taps" request into spaced LOAD/MOVE pulses.
// Latency: DONE 1 cycle after accept for empty requests, else setup + pulses*(1+MOVE_GAP) + hold + 1.
// Backpressure: REQ_READY only in IDLE; optional pause bracketing when LANE_DLY_MOVE_PAUSE_EN is defined.
module lane_dly_move_ctrl #(
  parameter int TAP_W       = 8,
  parameter int LOAD_VAL    = 1,
  parameter int MAX_TAP     = 255,
  parameter int PAUSE_SETUP = 2,
  parameter int PAUSE_HOLD  = 2,
  parameter int MOVE_GAP    = 3
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_SEL,
  input  logic             REQ_LOAD,
  input  logic             REQ_DIR,
  input  logic [TAP_W-1:0] REQ_COUNT,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] RX_TAP,
  output logic [TAP_W-1:0] TX_TAP,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_MOVE,
  output logic             HS_IO_CLK_PAUSE,
  input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);

  localparam int TMR_W = 16;
  localparam logic [TAP_W-1:0] LOAD_T    = TAP_W'(LOAD_VAL);
  localparam logic [TAP_W-1:0] MAX_T     = TAP_W'(MAX_TAP);
  localparam logic [TMR_W-1:0] PRE_LAST  = TMR_W'(PAUSE_SETUP - 1);
  localparam logic [TMR_W-1:0] POST_LAST = TMR_W'(PAUSE_HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(MOVE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_LOAD, S_MOVE, S_GAP, S_POST, S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_start_st;   // first state after accept for a non-empty request
  state_t           w_end_st;     // state after the last gap or a refused move
  logic             r_sel;
  logic             r_dir;
  logic             r_load;
  logic             r_err;
  logic [TAP_W-1:0] r_cnt;
  logic [TAP_W-1:0] r_rx_tap;
  logic [TAP_W-1:0] r_tx_tap;
  logic [TAP_W-1:0] r_prev_tap;   // tap value before the most recent LOAD/MOVE, for undo
  logic [TMR_W-1:0] r_tmr;
  logic             w_accept;
  logic             w_oor;
  logic             w_at_limit;
  logic [TAP_W-1:0] w_cur_tap;
  logic [TAP_W-1:0] w_moved_tap;
  logic             w_tap_we;
  logic [TAP_W-1:0] w_tap_wd;

  assign w_accept    = REQ_VALID & REQ_READY;
  assign w_cur_tap   = r_sel ? r_tx_tap : r_rx_tap;
  assign w_oor       = r_sel ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
  assign w_at_limit  = r_dir ? (w_cur_tap == MAX_T) : (w_cur_tap == '0);
  assign w_moved_tap = r_dir ? (w_cur_tap + 1'b1) : (w_cur_tap - 1'b1);
  assign RX_TAP      = r_rx_tap;
  assign TX_TAP      = r_tx_tap;

`ifdef LANE_DLY_MOVE_PAUSE_EN
  assign w_start_st = S_PRE;
  assign w_end_st   = S_POST;
`else
  // Without pause bracketing the sequence starts and ends directly on the pulse states.
  assign w_start_st = REQ_LOAD ? S_LOAD : S_MOVE;
  assign w_end_st   = S_FIN;
`endif

  // State register.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; the move limit is checked before a pulse is issued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (!REQ_LOAD && REQ_COUNT == '0) ? S_FIN : w_start_st;
      S_PRE:  if (r_tmr == PRE_LAST) w_state_nxt = r_load ? S_LOAD : S_MOVE;
      S_LOAD: w_state_nxt = S_GAP;
      S_MOVE: w_state_nxt = w_at_limit ? w_end_st : S_GAP;
      S_GAP: begin
        if (w_oor)                  w_state_nxt = w_end_st;
        else if (r_tmr == GAP_LAST) w_state_nxt = (r_cnt != '0) ? S_MOVE : w_end_st;
      end
      S_POST: if (r_tmr == POST_LAST) w_state_nxt = S_FIN;
      S_FIN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state; MOVE is suppressed when the limit refuses it.
  always_comb begin
    REQ_READY            = (r_state == S_IDLE);
    DONE                 = (r_state == S_FIN);
    ERR                  = (r_state == S_FIN) & r_err;
    DELAY_LINE_SEL       = (r_state != S_IDLE) & r_sel;
    DELAY_LINE_DIRECTION = (r_state != S_IDLE) & r_dir;
    DELAY_LINE_LOAD      = (r_state == S_LOAD);
    DELAY_LINE_MOVE      = (r_state == S_MOVE) & ~w_at_limit;
`ifdef LANE_DLY_MOVE_PAUSE_EN
    HS_IO_CLK_PAUSE      = (r_state == S_PRE) | (r_state == S_LOAD) | (r_state == S_MOVE) |
                           (r_state == S_GAP) | (r_state == S_POST);
`else
    HS_IO_CLK_PAUSE      = 1'b0;
`endif
  end

  // Dwell timer for PRE/GAP/POST: restarts on every state change.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N)                   r_tmr <= '0;
    else if (w_state_nxt != r_state) r_tmr <= '0;
    else                            r_tmr <= r_tmr + 1'b1;
  end

  // Request latch, remaining count, error flag and undo snapshot.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      r_sel      <= 1'b0;
      r_dir      <= 1'b0;
      r_load     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_prev_tap <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_sel  <= REQ_SEL;
          r_dir  <= REQ_DIR;
          r_load <= REQ_LOAD;
          r_cnt  <= REQ_COUNT;
          r_err  <= 1'b0;
        end
        S_LOAD: r_prev_tap <= w_cur_tap;
        S_MOVE: begin
          if (w_at_limit) begin
            r_err <= 1'b1;
          end else begin
            r_prev_tap <= w_cur_tap;
            r_cnt      <= r_cnt - 1'b1;
          end
        end
        S_GAP: if (w_oor) r_err <= 1'b1;
        default: ;
      endcase
    end
  end

  // Single write port for the selected tap: load, step, or undo after out-of-range.
  always_comb begin
    w_tap_we = 1'b0;
    w_tap_wd = w_cur_tap;
    case (r_state)
      S_LOAD: begin w_tap_we = 1'b1;        w_tap_wd = LOAD_T;      end
      S_MOVE: begin w_tap_we = ~w_at_limit; w_tap_wd = w_moved_tap; end
      S_GAP:  begin w_tap_we = w_oor;       w_tap_wd = r_prev_tap;  end
      default: ;
    endcase
  end

  // Tap position registers; only the selected line is ever written.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      r_rx_tap <= LOAD_T;
      r_tx_tap <= LOAD_T;
    end else if (w_tap_we) begin
      if (r_sel) r_tx_tap <= w_tap_wd;
      else       r_rx_tap <= w_tap_wd;
    end
  end

endmodule

// File: tb/tb_lane_dly_move_ctrl.sv
// Scoreboard bench for lane_dly_move_ctrl: a request-level model predicts DONE timing, ERR and taps.
// Directed cases cover the documented scenarios; randomized requests follow.
module tb_lane_dly_move_ctrl;
  localparam int LOAD_VAL = 1;
  localparam int MAX_TAP  = 255;
  localparam int G        = 3;
`ifdef LANE_DLY_MOVE_PAUSE_EN
  localparam int PS = 2;
  localparam int PH = 2;
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam int PS = 0;
  localparam int PH = 0;
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic       FAB_CLK = 1'b0;
  logic       RESET_N;
  logic       REQ_VALID, REQ_READY, REQ_SEL, REQ_LOAD, REQ_DIR;
  logic [7:0] REQ_COUNT;
  logic       DONE, ERR;
  logic [7:0] RX_TAP, TX_TAP;
  logic       DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE;
  logic       HS_IO_CLK_PAUSE;
  logic       RX_OOR, TX_OOR;

  lane_dly_move_ctrl dut (
    .FAB_CLK(FAB_CLK), .RESET_N(RESET_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_SEL(REQ_SEL),
    .REQ_LOAD(REQ_LOAD), .REQ_DIR(REQ_DIR), .REQ_COUNT(REQ_COUNT),
    .DONE(DONE), .ERR(ERR), .RX_TAP(RX_TAP), .TX_TAP(TX_TAP),
    .DELAY_LINE_SEL(DELAY_LINE_SEL), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .HS_IO_CLK_PAUSE(HS_IO_CLK_PAUSE),
    .RX_DELAY_LINE_OUT_OF_RANGE(RX_OOR), .TX_DELAY_LINE_OUT_OF_RANGE(TX_OOR)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int cyc = 0;
  always @(posedge FAB_CLK) cyc <= cyc + 1;

  typedef struct {
    int done_cyc;
    bit err;
    int rx;
    int tx;
    int nload;
    int nmove;
    bit sel;
    bit dir;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_rx, m_tx;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: checks every pulse and pops the scoreboard on each DONE.
  initial begin
    int   np_load;
    int   np_move;
    exp_t e;
    np_load = 0;
    np_move = 0;
    forever begin
      @(negedge FAB_CLK);
      if (!RESET_N) begin
        np_load = 0;
        np_move = 0;
        continue;
      end
      if (DELAY_LINE_LOAD || DELAY_LINE_MOVE) begin
        chk("load_move_overlap", DELAY_LINE_LOAD & DELAY_LINE_MOVE, 0);
        chk("pause_at_pulse", HS_IO_CLK_PAUSE, PAUSE_ON);
        chk("pulse_has_request", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          chk("pulse_sel", DELAY_LINE_SEL, sb[0].sel);
          chk("pulse_dir", DELAY_LINE_DIRECTION, sb[0].dir);
        end
        if (DELAY_LINE_LOAD) np_load++;
        if (DELAY_LINE_MOVE) np_move++;
      end
      if (DONE) begin
        chk("done_has_request", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("err", ERR, e.err);
          chk("rx_tap", RX_TAP, e.rx);
          chk("tx_tap", TX_TAP, e.tx);
          chk("load_pulses", np_load, e.nload);
          chk("move_pulses", np_move, e.nmove);
          chk("pause_at_done", HS_IO_CLK_PAUSE, 0);
          chk("ready_at_done", REQ_READY, 0);
        end
        np_load = 0;
        np_move = 0;
      end
    end
  end

  // Issue one request; inj>0 raises the selected OOR in gap cycle g after pulse #inj,
  // rst_at>0 pulses RESET_N in the gap after pulse #rst_at.
  task automatic do_req(input bit sel, input bit load, input bit dir, input int cnt,
                        input int inj, input int g, input int rst_at);
    exp_t e;
    int   t, prev, lat, k, rem, nl, nm, pulses, bound;
    bit   err, stop, fired;
    bound = 0;
    while (!REQ_READY && bound < 3000) begin
      @(negedge FAB_CLK);
      bound++;
    end
    chk("ready_wait", REQ_READY, 1);
    // Request-level model.
    t = sel ? m_tx : m_rx;
    err = 0; nl = 0; nm = 0; k = 0; stop = 0;
    if (!load && cnt == 0) begin
      lat = 1;
    end else begin
      lat = 1 + PS;
      if (load) begin
        k++; prev = t; t = LOAD_VAL; nl = 1;
        if (inj == k) begin t = prev; err = 1; lat += g + 2; stop = 1; end
        else lat += 1 + G;
      end
      rem = cnt;
      while (!stop && rem > 0) begin
        if ((dir && t == MAX_TAP) || (!dir && t == 0)) begin
          err = 1; lat += 1; stop = 1;
        end else begin
          k++; prev = t; t = dir ? t + 1 : t - 1; nm++; rem--;
          if (inj == k) begin t = prev; err = 1; lat += g + 2; stop = 1; end
          else lat += 1 + G;
        end
      end
      lat += PH;
    end
    e.done_cyc = cyc + lat;
    e.err = err; e.nload = nl; e.nmove = nm; e.sel = sel; e.dir = dir;
    e.rx = sel ? m_rx : t;
    e.tx = sel ? t : m_tx;
    sb.push_back(e);
    m_rx = e.rx;
    m_tx = e.tx;
    REQ_VALID = 1; REQ_SEL = sel; REQ_LOAD = load; REQ_DIR = dir; REQ_COUNT = 8'(cnt);
    @(negedge FAB_CLK);
    // Busy-time garbage that must be ignored.
    REQ_VALID = 1'b1; REQ_SEL = 1'($urandom); REQ_LOAD = 1'($urandom);
    REQ_DIR = 1'($urandom); REQ_COUNT = 8'($urandom);
    pulses = 0; fired = 0; bound = 0;
    forever begin
      if (DELAY_LINE_LOAD || DELAY_LINE_MOVE) pulses++;
      if (rst_at > 0 && pulses == rst_at) begin
        @(negedge FAB_CLK);
        REQ_VALID = 0;
        RESET_N = 0;
        @(negedge FAB_CLK);
        sb.delete();
        chk("rst_ready", REQ_READY, 1);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_pause", HS_IO_CLK_PAUSE, 0);
        chk("rst_sel", DELAY_LINE_SEL, 0);
        chk("rst_dir", DELAY_LINE_DIRECTION, 0);
        chk("rst_move", DELAY_LINE_MOVE, 0);
        chk("rst_rx_tap", RX_TAP, LOAD_VAL);
        chk("rst_tx_tap", TX_TAP, LOAD_VAL);
        RESET_N = 1;
        m_rx = LOAD_VAL;
        m_tx = LOAD_VAL;
        repeat (30) @(negedge FAB_CLK);
        break;
      end
      if (!fired && inj > 0 && pulses == inj) begin
        fired = 1;
        repeat (g + 1) begin
          @(negedge FAB_CLK);
          REQ_VALID = 0;
        end
        if (sel) TX_OOR = 1; else RX_OOR = 1;
        @(negedge FAB_CLK);
        RX_OOR = 0; TX_OOR = 0;
      end
      if (DONE) break;
      if (bound > 3000) begin
        chk("done_timeout", 0, 1);
        break;
      end
      bound++;
      @(negedge FAB_CLK);
      REQ_VALID = 0;
      if (sel) RX_OOR = 1'($urandom); else TX_OOR = 1'($urandom);
    end
    REQ_VALID = 0;
    RX_OOR = 0;
    TX_OOR = 0;
  endtask

  initial begin
    RESET_N = 0; REQ_VALID = 0; REQ_SEL = 0; REQ_LOAD = 0; REQ_DIR = 0; REQ_COUNT = '0;
    RX_OOR = 0; TX_OOR = 0;
    m_rx = LOAD_VAL;
    m_tx = LOAD_VAL;
    repeat (3) @(negedge FAB_CLK);
    chk("reset_ready", REQ_READY, 1);
    chk("reset_done", DONE, 0);
    chk("reset_err", ERR, 0);
    chk("reset_pause", HS_IO_CLK_PAUSE, 0);
    chk("reset_load", DELAY_LINE_LOAD, 0);
    chk("reset_move", DELAY_LINE_MOVE, 0);
    chk("reset_rx_tap", RX_TAP, LOAD_VAL);
    chk("reset_tx_tap", TX_TAP, LOAD_VAL);
    RESET_N = 1;
    @(negedge FAB_CLK);

    do_req(0, 0, 1, 3,   0, 0, 0);  // RX up 3 from 1
    do_req(1, 0, 1, 39,  0, 0, 0);  // TX to 40
    do_req(1, 1, 0, 5,   0, 0, 0);  // load, one move to 0, then refused
    do_req(0, 1, 1, 10,  5, 1, 0);  // OOR in gap after 4th MOVE
    do_req(0, 0, 0, 0,   0, 0, 0);  // empty request
    do_req(1, 1, 1, 0,   0, 0, 0);  // load only
    do_req(0, 0, 1, 5,   0, 0, 2);  // reset between 2nd and 3rd MOVE
    do_req(0, 0, 1, 255, 0, 0, 0);  // run into MAX_TAP
    do_req(1, 0, 0, 3,   0, 0, 0);  // run into zero
    do_req(0, 1, 0, 2,   1, 2, 0);  // OOR after LOAD undoes the load

    for (int i = 0; i < 120; i++) begin
      do_req(1'($urandom), ($urandom % 4) == 0, 1'($urandom),
             (($urandom % 8) == 0) ? int'($urandom % 64) : int'($urandom % 9),
             (($urandom % 4) == 0) ? int'(1 + $urandom % 4) : 0,
             int'($urandom % G), 0);
    end

    repeat (5) @(negedge FAB_CLK);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
